// File: rtl/vga_timing_defs.sv
// Shared VGA 640x480@60 timing constants and vertical FSM encodings.
// Also used by the horizontal counter for its 800-column line length.
package vga_timing_defs;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_TOTAL      = 10'd800;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // 0 = active-low sync pulses, as in the 640x480@60 standard.
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    V_ACTIVE_ST = 2'd0,
    V_FRONT_ST  = 2'd1,
    V_SYNC_ST   = 2'd2,
    V_BACK_ST   = 2'd3
  } vstate_t;

endpackage

// File: rtl/vga_vertical_timing.sv
// Vertical line counter and region FSM downstream of the horizontal counter.
// All outputs are registered so downstream logic sees glitch-free timing.
//
// state       | meaning
// ------------+-----------------------------------------
// V_ACTIVE_ST | lines 0..479, visible rows
// V_FRONT_ST  | lines 480..489, vertical front porch
// V_SYNC_ST   | lines 490..491, vsync asserted
// V_BACK_ST   | lines 492..524, vertical back porch
module vga_vertical_timing
  import vga_timing_defs::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] cntHorizontal,
  input  logic       vflag,
  output logic [9:0] cntVertical,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick
);

  vstate_t    state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [9:0] next_line;
  logic       tick_d;

  // The wrap test comes before the increment, so the count never overflows.
  assign next_line = (cnt_q == V_TOTAL - 10'd1) ? 10'd0 : cnt_q + 10'd1;

  // Next line, next region and frame tick; only vflag advances anything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (vflag) begin
      cnt_d  = next_line;
      tick_d = (cnt_q == V_TOTAL - 10'd1);
    end
    case (state_q)
      V_ACTIVE_ST: if (vflag && next_line == V_VISIBLE) state_d = V_FRONT_ST;
      V_FRONT_ST:  if (vflag && next_line == V_VISIBLE + V_FRONT) state_d = V_SYNC_ST;
      V_SYNC_ST:   if (vflag && next_line == V_VISIBLE + V_FRONT + V_SYNC) state_d = V_BACK_ST;
      V_BACK_ST:   if (vflag && next_line == 10'd0) state_d = V_ACTIVE_ST;
      default: begin
        state_d = V_ACTIVE_ST;
        cnt_d   = 10'd0;
        tick_d  = 1'b0;
      end
    endcase
  end

  // Line counter, region state and frame tick registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= V_ACTIVE_ST;
      cnt_q      <= 10'd0;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_tick <= tick_d;
    end
  end

  // Registered sync and blanking outputs; vsync follows the new state so it
  // changes on the same edge as the line count, video_on uses the old state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hsync    <= ~SYNC_ACTIVE;
      vsync    <= ~SYNC_ACTIVE;
      video_on <= 1'b0;
    end else begin
      hsync    <= (cntHorizontal >= H_SYNC_START && cntHorizontal < H_SYNC_END)
                  ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync    <= (state_d == V_SYNC_ST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on <= (cntHorizontal < H_VISIBLE) && (state_q == V_ACTIVE_ST);
    end
  end

  assign cntVertical = cnt_q;

endmodule
